// File: rtl/conv_pkg.sv
// Shared types and width helpers for the bit-to-byte conversion blocks.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package conv_pkg;

  // One octet of a packed output beat.
  typedef logic [7:0] byte_t;

  // Number of bytes needed to hold n bits (round up).
  function automatic int ceil_div8(input int n);
    return (n + 7) / 8;
  endfunction

  // Width of a counter that must represent 0..n inclusive.
  function automatic int clog2p1(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bits2bytes.sv
// Combinational slicer: flat bit vector into little-endian byte lanes.
// Latency: 0 cycles, pure wiring.
// Backpressure: none; no handshake, output follows input.
module bits2bytes
  import conv_pkg::*;
#(
  parameter int N_BYTES = 4
) (
  input  logic [N_BYTES*8-1:0] bits_i,
  output byte_t [N_BYTES-1:0]  bytes_o
);

  // Byte i carries bits [i*8 +: 8]; bit 0 of the vector lands in bit 0 of byte 0.
  for (genvar i = 0; i < N_BYTES; i++) begin : g_byte
    assign bytes_o[i] = bits_i[i*8 +: 8];
  end

endmodule

// File: rtl/stream_bits2bytes_packer.sv
// Packs D_WIDTH-bit symbols little-endian into OUT_BYTES-wide beats; last flushes a zero-padded partial beat.
// Latency: a beat is presented the cycle after the symbol completing it is accepted.
// Backpressure: in_ready depends on registered state only; out_ready stall holds the beat stable.
module stream_bits2bytes_packer
  import conv_pkg::*;
#(
  parameter int D_WIDTH   = 12,
  parameter int OUT_BYTES = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [D_WIDTH-1:0]                   in_data_i,
  input  logic                                 in_last_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [OUT_BYTES-1:0][7:0]            out_bytes_o,
  output logic [clog2p1(OUT_BYTES)-1:0]        out_nbytes_o,
  output logic                                 out_last_o
);

  localparam int OUT_W = OUT_BYTES * 8;
  localparam int ACC_W = OUT_W + D_WIDTH;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam int NB_W  = clog2p1(OUT_BYTES);

  localparam logic [CNT_W-1:0] OUT_W_C = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0] D_W_C   = CNT_W'(D_WIDTH);

  // Accumulator holds valid bits in [cnt-1:0]; everything above cnt is kept at zero
  // so the final partial beat is zero padded without any masking.
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_pend_q, flush_pend_d;

  logic             in_fire;
  logic             out_fire;
  logic [ACC_W-1:0] acc_emit;
  logic [CNT_W-1:0] cnt_emit;

  // Handshake-facing flags, all decoded from registered state.
  always_comb begin
    in_ready_o  = !flush_pend_q && (cnt_q <= OUT_W_C);
    out_valid_o = (cnt_q >= OUT_W_C) || (flush_pend_q && (cnt_q != '0));
    out_last_o  = flush_pend_q && (cnt_q <= OUT_W_C) && out_valid_o;
    if (out_last_o) begin
      out_nbytes_o = NB_W'(ceil_div8(int'(cnt_q)));
    end else if (out_valid_o) begin
      out_nbytes_o = NB_W'(OUT_BYTES);
    end else begin
      out_nbytes_o = '0;
    end
  end

  assign in_fire  = in_valid_i && in_ready_o;
  assign out_fire = out_valid_o && out_ready_i;

  // Next state: drain one beat first, then append the incoming symbol above what remains.
  always_comb begin
    acc_emit     = acc_q;
    cnt_emit     = cnt_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;

    if (out_fire) begin
      acc_emit = acc_q >> OUT_W;
      cnt_emit = (cnt_q >= OUT_W_C) ? (cnt_q - OUT_W_C) : '0;
      // The last beat of a stream retires the pending flush.
      if (out_last_o) begin
        flush_pend_d = 1'b0;
      end
    end

    acc_d = acc_emit;
    cnt_d = cnt_emit;

    // in_ready guarantees cnt_emit <= OUT_W here, so the symbol always fits.
    if (in_fire) begin
      acc_d = acc_emit | (ACC_W'(in_data_i) << cnt_emit);
      cnt_d = cnt_emit + D_W_C;
      if (in_last_i) begin
        flush_pend_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // The beat is always the low OUT_W bits of the accumulator.
  bits2bytes #(
    .N_BYTES (OUT_BYTES)
  ) u_bits2bytes (
    .bits_i  (acc_q[OUT_W-1:0]),
    .bytes_o (out_bytes_o)
  );

endmodule
